// File: rtl/gfx_pkg.sv
// Shared graphics types and framebuffer geometry used by the draw engines
// (fill now; line and blit engines later).
package gfx_pkg;

   localparam int FB_W    = 160;
   localparam int FB_H    = 120;
   localparam int ADDR_W  = 15;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 12;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
      rgb444_t            color;
   } rect_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW,
      DONE
   } fill_state_t;

   function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      return (a < b) ? b : a;
   endfunction

endpackage

// File: rtl/rect_normalize_clip.sv
// Orders the corners of a rectangle command and clips the far edges to the
// visible area; empty flags a rectangle lying entirely off-screen.
module rect_normalize_clip
   import gfx_pkg::*;
#(
   parameter int CLIP_W = FB_W,
   parameter int CLIP_H = FB_H
) (
   input  rect_t              rect,
   output logic [COORD_W-1:0] x_lo,
   output logic [COORD_W-1:0] x_hi,
   output logic [COORD_W-1:0] y_lo,
   output logic [COORD_W-1:0] y_hi,
   output rgb444_t            color,
   output logic               empty
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(CLIP_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(CLIP_H - 1);

   logic [COORD_W-1:0] x_far;
   logic [COORD_W-1:0] y_far;

   always_comb begin
      x_lo  = coord_min(rect.x0, rect.x1);
      x_far = coord_max(rect.x0, rect.x1);
      y_lo  = coord_min(rect.y0, rect.y1);
      y_far = coord_max(rect.y0, rect.y1);
      // Only the far edges need clipping; a near edge past the limit means nothing is visible.
      x_hi  = coord_min(x_far, X_MAX);
      y_hi  = coord_min(y_far, Y_MAX);
      empty = (x_lo > X_MAX) || (y_lo > Y_MAX);
   end

   assign color = rect.color;

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches a fill command, normalises and clips it, then
// streams one framebuffer write per granted cycle in row-major order.
module rect_fill_engine
   import gfx_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   input  logic               wr_ready,
   output logic               busy,
   output logic               done
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready high
   // SETUP | latched command normalised/clipped, first address formed
   // DRAW  | one pixel write presented, advances only when granted
   // DONE  | single-cycle completion pulse, then back to IDLE

   fill_state_t        state;
   rect_t              rect;
   rgb444_t            fill_color;
   logic [COORD_W-1:0] x_lo;
   logic [COORD_W-1:0] x_hi;
   logic [COORD_W-1:0] y_lo;
   logic [COORD_W-1:0] y_hi;
   logic               empty;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [ADDR_W-1:0]  row_base;
   logic [ADDR_W-1:0]  setup_base;
   logic [ADDR_W-1:0]  next_row_base;

   rect_normalize_clip #(
      .CLIP_W (FB_W),
      .CLIP_H (FB_H)
   ) u_clip (
      .rect  (rect),
      .x_lo  (x_lo),
      .x_hi  (x_hi),
      .y_lo  (y_lo),
      .y_hi  (y_hi),
      .color (fill_color),
      .empty (empty)
   );

   // The only multiply; after SETUP rows advance by adding FB_W.
   assign setup_base    = ADDR_W'(32'(y_lo) * FB_W);
   assign next_row_base = row_base + ADDR_W'(FB_W);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rect      <= '0;
         x         <= '0;
         y         <= '0;
         row_base  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  rect.x0    <= cmd_x0;
                  rect.y0    <= cmd_y0;
                  rect.x1    <= cmd_x1;
                  rect.y1    <= cmd_y1;
                  rect.color <= rgb444_t'(cmd_color);
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (empty) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  row_base <= setup_base;
                  x        <= x_lo;
                  y        <= y_lo;
                  wr_addr  <= setup_base + ADDR_W'(x_lo);
                  wr_data  <= fill_color;
                  wr_en    <= 1'b1;
                  state    <= DRAW;
               end
            end
            DRAW: begin
               // wr_addr tracks row_base + x incrementally; a stall freezes everything.
               if (wr_ready) begin
                  if (x < x_hi) begin
                     x       <= x + COORD_W'(1);
                     wr_addr <= wr_addr + ADDR_W'(1);
                  end else if (y < y_hi) begin
                     x        <= x_lo;
                     y        <= y + COORD_W'(1);
                     row_base <= next_row_base;
                     wr_addr  <= next_row_base + ADDR_W'(x_lo);
                  end else begin
                     wr_en <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               wr_en     <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Framebuffer writer for the graphics processor: accepts a rectangle-fill command and streams one pixel write per cycle into the shared framebuffer port. The VGA scan-out side reads this framebuffer using pixel_x/pixel_y/pixel_addr; this block is the write-side counterpart. It produces addresses with the same linear mapping, addr = y*FB_W + x. The memory arbiter stalls this block via wr_ready while scan-out owns the port.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
ADDR_W, 15, framebuffer address width; FB_W*FB_H must be <= 2**ADDR_W
COORD_W, 10, command coordinate width, matching pixel_x/pixel_y
COLOR_W, 12, pixel width, RGB 4:4:4

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  inclusive corners, any order
cmd_color  in  COLOR_W  fill colour
wr_en  out  1  write request
wr_addr  out  ADDR_W  framebuffer address
wr_data  out  COLOR_W  pixel value
wr_ready  in  1  arbiter grants the write this cycle
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=IDLE, cmd_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- Handshakes:
  - A command is accepted on a cycle with cmd_valid && cmd_ready, and its fields are latched that cycle.
  - cmd_ready=1 only in IDLE.
  - A write completes on a cycle with wr_en && wr_ready.
  - While wr_en=1 && wr_ready=0, wr_addr and wr_data hold stable and the engine does not advance.
- States:
  - IDLE: wait for accept, then go to SETUP. busy=0.
  - SETUP (1 cycle):
    - Normalise: x_lo=min(x0,x1), x_hi=max(x0,x1); same for y.
    - Clip: x_hi=min(x_hi,FB_W-1), y_hi=min(y_hi,FB_H-1).
    - If x_lo>=FB_W or y_lo>=FB_H, go to DONE with no writes.
    - Otherwise row_base=y_lo*FB_W (constant multiply allowed here only), x=x_lo, y=y_lo, then go to DRAW.
  - DRAW:
    - wr_en=1, wr_addr=row_base+x, wr_data=latched colour.
    - On each completed write: if x<x_hi then x++; else x=x_lo, y++, row_base+=FB_W.
    - The completed write at (x_hi,y_hi) goes to DONE; wr_en=0 from the next cycle.
  - DONE (1 cycle): done=1, then return to IDLE.
- busy=1 in SETUP, DRAW and DONE.
- Write order is row-major: increasing x, then increasing y. No pixel is skipped or written twice.
- Latency with wr_ready=1:
  - First wr_en is 2 cycles after the accept cycle.
  - For N pixels, done asserts at accept+2+N.
  - For a fully clipped command, done asserts at accept+2.
- Width rules:
  - Coordinates are compared unsigned at COORD_W.
  - row_base and wr_addr are ADDR_W; no overflow is possible after clipping.
- Reset mid-DRAW: the next cycle has wr_en=0 and cmd_ready=1. The partial rectangle is abandoned and no done pulse is produced.
- cmd_valid asserted while busy is ignored; its fields are not latched.

Decomposition:
- Package gfx_pkg:
  - FB_W, FB_H, ADDR_W, COLOR_W constants.
  - typedef rgb444_t with 4-bit r/g/b fields.
  - typedef rect_t holding x0,y0,x1,y1 and colour.
  - enum fill_state_t {IDLE, SETUP, DRAW, DONE}.
- One combinational sub-module, rect_normalize_clip: takes rect_t and produces x_lo/x_hi/y_lo/y_hi plus an empty flag. It is reusable by future line/blit engines.

Test Plan:
1. Single pixel: cmd (5,7)-(5,7), colour 0xF00, wr_ready=1 -> exactly one write, addr 1125, data 0xF00; done at accept+3.
2. 4x2 rect: (10,20)-(13,21), colour 0x0F0 -> 8 writes at addrs 3210,3211,3212,3213,3370,3371,3372,3373 in that order; done at accept+10.
3. Swapped corners: (13,21)-(10,20) -> identical write sequence to scenario 2.
4. Clipping: (150,118)-(200,300) -> 20 writes covering x 150..159 and y 118..119; first addr 19030, last addr 19199.
5. Fully off-screen: (170,5)-(180,6) -> zero wr_en cycles; done at accept+2; cmd_ready=1 the cycle after done.
6. Stall and reset:
   - Scenario 2 with wr_ready low for 3 cycles at the 3rd pixel -> addr 3212 held for 4 cycles; no duplicate or skipped address; done at accept+13.
   - Separately, Reset asserted during DRAW -> wr_en=0 and cmd_ready=1 the next cycle, and no done pulse.
